vector_shift_unit_p: RTL and testbench

Parametrised vector shift functional unit for the Cray-XMP CPU vector section. It is the next generation of the fixed 64-bit shift unit. It accepts one vector instruction at a time and streams VL elements of register Vj from the vector register file. Each element is shifted by a count derived from Ak/k, and the unit returns one result per clock with a valid strobe and a busy reservation. New relative to the fixed unit: configurable width, register count and VL width; arithmetic-right and rotate-left modes; explicit end-of-vector zero fill for double shifts; busy-start rejection.

---
 rtl/vector_shift_unit_p.sv | 143 ++++++++++++++
 tb/tb_vector_shift_unit_p.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_shift_unit_p.sv
// Vector shift functional unit: streams VL elements of Vj, shifts each by a count taken from Ak/k.
// Fixed 4-cycle functional time, one result per clock; supports single, double, arithmetic and rotate shifts.
module vector_shift_unit_p #(
  parameter int DATA_W = 64,
  parameter int NREG   = 8,
  parameter int VL_W   = 7,
  parameter int AK_W   = 24,
  localparam int J_W   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [2:0]             i_mode,
  input  logic [VL_W-1:0]        i_vl,
  input  logic [J_W-1:0]         i_j,
  input  logic [2:0]             i_k,
  input  logic [AK_W-1:0]        i_ak,
  input  logic [NREG*DATA_W-1:0] i_vdata,
  output logic                   o_rd_en,
  output logic [VL_W-1:0]        o_rd_idx,
  output logic [DATA_W-1:0]      o_result,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_start_err
);
  localparam int N_W = $clog2(2*DATA_W + 1);
  localparam logic [N_W-1:0] N_MAX = N_W'(2*DATA_W);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             r_state;
  logic [2:0]             r_mode;
  logic [J_W-1:0]         r_j;
  logic [VL_W-1:0]        r_vl, r_idx;
  logic [N_W-1:0]         r_n;
  logic [2:0]             r_vld_pipe;
  logic [DATA_W-1:0]      r_a, r_b, r_c, r_result;
  logic                   r_a_first, r_a_last, r_b_first, r_b_last, r_last, r_start_err;

  logic [NREG-1:0][DATA_W-1:0] w_regs;
  logic                   w_busy, w_legal, w_accept, w_rd_en, w_rd_last;
  logic [N_W-1:0]         w_n_start, w_rot;
  logic [DATA_W-1:0]      w_nxt, w_prv, w_res;
  logic [2*DATA_W-1:0]    w_dl, w_dr;

  assign w_regs    = i_vdata;
  assign w_busy    = (r_state != S_IDLE);
  assign w_legal   = (i_mode <= 3'd5);
  assign w_accept  = i_start & ~w_busy & w_legal & (i_vl != '0);
  assign w_n_start = (i_k == 3'd0) ? N_W'(1) :
                     (i_ak > AK_W'(2*DATA_W)) ? N_MAX : i_ak[N_W-1:0];
  assign w_rd_en   = (r_state == S_READ);
  assign w_rd_last = (r_idx == r_vl - VL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_mode  <= '0;
      r_j     <= '0;
      r_vl    <= '0;
      r_n     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_READ;
          r_idx   <= '0;
          r_mode  <= i_mode;
          r_j     <= i_j;
          r_vl    <= i_vl;
          r_n     <= w_n_start;
        end
        S_READ: begin
          if (w_rd_last) begin
            r_state <= S_DRAIN;
            r_idx   <= '0;
          end else begin
            r_idx   <= r_idx + VL_W'(1);
          end
        end
        S_DRAIN: if (r_vld_pipe[2] & r_last) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // r_a holds V[e+1] and r_c holds V[e-1] while r_b (V[e]) is shifted, so
  // both double shifts see their neighbour without extra latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_a_first   <= 1'b0;
      r_a_last    <= 1'b0;
      r_b_first   <= 1'b0;
      r_b_last    <= 1'b0;
      r_last      <= 1'b0;
      r_result    <= '0;
      r_start_err <= 1'b0;
    end else begin
      r_vld_pipe  <= {r_vld_pipe[1:0], w_rd_en};
      r_a         <= w_regs[r_j];
      r_a_first   <= (r_idx == '0);
      r_a_last    <= w_rd_last;
      r_b         <= r_a;
      r_b_first   <= r_a_first;
      r_b_last    <= r_a_last;
      r_c         <= r_b;
      r_result    <= r_vld_pipe[1] ? w_res : '0;
      r_last      <= r_vld_pipe[1] & r_b_last;
      r_start_err <= i_start & (w_busy | ~w_legal);
    end
  end

  assign w_nxt = r_b_last  ? '0 : r_a;
  assign w_prv = r_b_first ? '0 : r_c;
  assign w_dl  = {r_b, w_nxt} << r_n;
  assign w_dr  = {w_prv, r_b} >> r_n;
  assign w_rot = r_n % N_W'(DATA_W);

  always_comb begin
    w_res = '0;
    case (r_mode)
      3'd0: w_res = r_b << r_n;
      3'd1: w_res = r_b >> r_n;
      3'd2: w_res = w_dl[2*DATA_W-1 -: DATA_W];
      3'd3: w_res = w_dr[DATA_W-1:0];
      3'd4: w_res = DATA_W'($signed(r_b) >>> r_n);
      3'd5: w_res = (r_b << w_rot) | (r_b >> (N_W'(DATA_W) - w_rot));
      default: w_res = '0;
    endcase
  end

  assign o_rd_en     = w_rd_en;
  assign o_rd_idx    = r_idx;
  assign o_result    = r_result;
  assign o_valid     = r_vld_pipe[2];
  assign o_busy      = w_busy;
  assign o_start_err = r_start_err;
endmodule

// File: tb/tb_vector_shift_unit_p.sv
// Directed bench for vector_shift_unit_p: per-scenario tasks with hand-computed results.
// Outputs are recorded per cycle after issue (c=1 is the cycle after the accepting edge) and compared inline.
module tb_vector_shift_unit_p;
  localparam int DW = 64, NR = 8, VW = 7, AW = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start;
  logic [2:0]     i_mode, i_j, i_k;
  logic [VW-1:0]  i_vl;
  logic [AW-1:0]  i_ak;
  logic [NR*DW-1:0] i_vdata;
  logic           o_rd_en, o_valid, o_busy, o_start_err;
  logic [VW-1:0]  o_rd_idx;
  logic [DW-1:0]  o_result;

  logic [DW-1:0]  vmem [NR][128];
  int checks = 0, failures = 0;

  logic           cv [32], cb [32], ce [32], cerr [32];
  logic [VW-1:0]  ci [32];
  logic [DW-1:0]  cr [32];
  int             inj_c = 0, rst_c = 0;
  logic [2:0]     inj_mode, inj_j, inj_k;
  logic [VW-1:0]  inj_vl;
  logic [AW-1:0]  inj_ak;

  vector_shift_unit_p #(.DATA_W(DW), .NREG(NR), .VL_W(VW), .AK_W(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_vl(i_vl),
    .i_j(i_j), .i_k(i_k), .i_ak(i_ak), .i_vdata(i_vdata),
    .o_rd_en(o_rd_en), .o_rd_idx(o_rd_idx), .o_result(o_result),
    .o_valid(o_valid), .o_busy(o_busy), .o_start_err(o_start_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_vdata = '0;
    for (int r = 0; r < NR; r++) i_vdata[r*DW +: DW] = vmem[r][o_rd_idx];
  end

  task automatic issue(input logic [2:0] m, input logic [VW-1:0] vl, input logic [2:0] j,
                       input logic [2:0] k, input logic [AW-1:0] ak);
    @(negedge clk);
    i_start = 1'b1; i_mode = m; i_vl = vl; i_j = j; i_k = k; i_ak = ak;
    @(posedge clk);
  endtask

  // Records outputs for n cycles; scrambles the instruction fields to show they are ignored.
  task automatic capture(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      rst = (c == rst_c);
      if (c == inj_c) begin
        i_start = 1'b1; i_mode = inj_mode; i_vl = inj_vl; i_j = inj_j; i_k = inj_k; i_ak = inj_ak;
      end else begin
        i_start = 1'b0; i_mode = 3'd7; i_vl = VW'($urandom);
        i_j = 3'($urandom); i_k = 3'($urandom); i_ak = AW'($urandom);
      end
      cv[c] = o_valid; cb[c] = o_busy; ce[c] = o_rd_en; cerr[c] = o_start_err;
      ci[c] = o_rd_idx; cr[c] = o_result;
    end
    i_start = 1'b0; rst = 1'b0; inj_c = 0; rst_c = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_mode = '0; i_vl = '0; i_j = '0; i_k = '0; i_ak = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_valid, o_busy, o_rd_en, o_start_err} !== 4'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b exp 0000", {o_valid, o_busy, o_rd_en, o_start_err});
    end
    checks++;
    if ({o_rd_idx, o_result} !== '0) begin
      failures++; $display("FAIL reset_data: got idx %0h res %0h exp 0", o_rd_idx, o_result);
    end
    rst = 1'b0;
  endtask

  task automatic test_streams();
    logic [2:0]    tm [3] = '{3'd0, 3'd3, 3'd2};
    logic [2:0]    tj [3] = '{3'd2, 3'd5, 3'd0};
    logic [VW-1:0] tv [3] = '{7'd4, 7'd3, 7'd2};
    logic [AW-1:0] ta [3] = '{24'd3, 24'd4, 24'd4};
    logic [DW-1:0] te [3][4] = '{
      '{64'd8, 64'd16, 64'd24, 64'd0},
      '{64'h0, 64'h1000_0000_0000_0000, 64'h2000_0000_0000_0000, 64'h0},
      '{64'h1F, 64'h0, 64'h0, 64'h0}};
    for (int t = 0; t < 3; t++) begin
      int vl;
      vl = int'(tv[t]);
      issue(tm[t], tv[t], tj[t], 3'd1, ta[t]);
      capture(vl + 5);
      for (int c = 1; c <= vl + 4; c++) begin
        logic ev, eb, er;
        ev = (c >= 4) && (c < 4 + vl);
        eb = (c <= vl + 3);
        er = (c <= vl);
        checks++;
        if (cv[c] !== ev) begin
          failures++; $display("FAIL stream%0d_valid c%0d: got %b exp %b", t, c, cv[c], ev);
        end
        if (ev) begin
          checks++;
          if (cr[c] !== te[t][c-4]) begin
            failures++; $display("FAIL stream%0d_result c%0d: got %h exp %h", t, c, cr[c], te[t][c-4]);
          end
        end
        checks++;
        if (cb[c] !== eb || ce[c] !== er) begin
          failures++; $display("FAIL stream%0d_busy_rd c%0d: got %b%b exp %b%b", t, c, cb[c], ce[c], eb, er);
        end
        if (er) begin
          checks++;
          if (ci[c] !== VW'(c - 1)) begin
            failures++; $display("FAIL stream%0d_idx c%0d: got %0d exp %0d", t, c, ci[c], c - 1);
          end
        end
      end
    end
  endtask

  task automatic test_single_elem();
    logic [2:0]    tm [5] = '{3'd4, 3'd5, 3'd1, 3'd0, 3'd5};
    logic [2:0]    tj [5] = '{3'd1, 3'd1, 3'd3, 3'd1, 3'd1};
    logic [2:0]    tk [5] = '{3'd1, 3'd1, 3'd0, 3'd1, 3'd1};
    logic [AW-1:0] ta [5] = '{24'd70, 24'd68, 24'd50, 24'hFF_FFFF, 24'd0};
    logic [DW-1:0] te [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h18, 64'h2, 64'h0, 64'h8000_0000_0000_0001};
    for (int t = 0; t < 5; t++) begin
      issue(tm[t], 7'd1, tj[t], tk[t], ta[t]);
      capture(5);
      checks++;
      if (cv[4] !== 1'b1 || cr[4] !== te[t]) begin
        failures++; $display("FAIL single%0d: got v%b %h exp v1 %h", t, cv[4], cr[4], te[t]);
      end
      checks++;
      if (cb[4] !== 1'b1 || cb[5] !== 1'b0 || cv[5] !== 1'b0) begin
        failures++; $display("FAIL single%0d_end: got busy %b%b valid %b exp 10 0", t, cb[4], cb[5], cv[5]);
      end
    end
  endtask

  task automatic test_busy_err();
    logic [DW-1:0] te [4] = '{64'd8, 64'd16, 64'd24, 64'd0};
    inj_c = 2; inj_mode = 3'd2; inj_vl = 7'd3; inj_j = 3'd5; inj_k = 3'd1; inj_ak = 24'd10;
    issue(3'd0, 7'd4, 3'd2, 3'd1, 24'd3);
    capture(10);
    checks++;
    if ({cerr[2], cerr[3], cerr[4]} !== 3'b010) begin
      failures++; $display("FAIL busy_err_pulse: got %b exp 010", {cerr[2], cerr[3], cerr[4]});
    end
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (cv[4+e] !== 1'b1 || cr[4+e] !== te[e]) begin
        failures++; $display("FAIL busy_err_stream e%0d: got v%b %h exp v1 %h", e, cv[4+e], cr[4+e], te[e]);
      end
    end
    checks++;
    if (cv[8] !== 1'b0 || cb[8] !== 1'b0 || ce[8] !== 1'b0) begin
      failures++; $display("FAIL busy_err_end: got v%b b%b r%b exp 000", cv[8], cb[8], ce[8]);
    end
  endtask

  task automatic test_illegal_and_vl0();
    logic [2:0]    tm [3] = '{3'd7, 3'd6, 3'd0};
    logic [VW-1:0] tv [3] = '{7'd4, 7'd4, 7'd0};
    logic          terr [3] = '{1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      logic act;
      issue(tm[t], tv[t], 3'd2, 3'd1, 24'd3);
      capture(6);
      act = 1'b0;
      for (int c = 1; c <= 6; c++) act = act | cb[c] | ce[c] | cv[c];
      checks++;
      if (act !== 1'b0) begin
        failures++; $display("FAIL reject%0d_activity: got %b exp 0", t, act);
      end
      checks++;
      if (cerr[1] !== terr[t] || cerr[2] !== 1'b0) begin
        failures++; $display("FAIL reject%0d_err: got %b%b exp %b0", t, cerr[1], cerr[2], terr[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    inj_c = 6; inj_mode = 3'd0; inj_vl = 7'd1; inj_j = 3'd2; inj_k = 3'd1; inj_ak = 24'd1;
    issue(3'd0, 7'd2, 3'd2, 3'd1, 24'd3);
    capture(12);
    checks++;
    if (cr[4] !== 64'd8 || cr[5] !== 64'd16 || cv[4] !== 1'b1 || cv[5] !== 1'b1) begin
      failures++; $display("FAIL b2b_first: got %h %h exp 8 10", cr[4], cr[5]);
    end
    checks++;
    if (cb[5] !== 1'b1 || cb[6] !== 1'b0 || cb[7] !== 1'b1) begin
      failures++; $display("FAIL b2b_busy: got %b%b%b exp 101", cb[5], cb[6], cb[7]);
    end
    checks++;
    if (ce[7] !== 1'b1 || ci[7] !== 7'd0 || cerr[7] !== 1'b0) begin
      failures++; $display("FAIL b2b_read: got rd%b idx%0d err%b exp rd1 idx0 err0", ce[7], ci[7], cerr[7]);
    end
    checks++;
    if ({cv[6], cv[7], cv[8], cv[9], cv[10], cv[11]} !== 6'b000010 || cr[10] !== 64'd2) begin
      failures++; $display("FAIL b2b_second: got v%b %h exp v000010 2",
                           {cv[6], cv[7], cv[8], cv[9], cv[10], cv[11]}, cr[10]);
    end
    checks++;
    if (cb[10] !== 1'b1 || cb[11] !== 1'b0) begin
      failures++; $display("FAIL b2b_end: got %b%b exp 10", cb[10], cb[11]);
    end
  endtask

  task automatic test_reset_mid();
    logic any_v;
    rst_c = 5;
    inj_c = 7; inj_mode = 3'd0; inj_vl = 7'd1; inj_j = 3'd2; inj_k = 3'd0; inj_ak = 24'd0;
    issue(3'd0, 7'd10, 3'd4, 3'd1, 24'd1);
    capture(13);
    checks++;
    if (cv[4] !== 1'b1 || cr[4] !== 64'd2) begin
      failures++; $display("FAIL rstmid_pre: got v%b %h exp v1 2", cv[4], cr[4]);
    end
    checks++;
    if ({cv[6], cb[6], ce[6], cerr[6]} !== 4'b0 || ci[6] !== '0 || cr[6] !== '0) begin
      failures++; $display("FAIL rstmid_zero: got %b idx%0d res %h exp 0", {cv[6], cb[6], ce[6], cerr[6]}, ci[6], cr[6]);
    end
    any_v = 1'b0;
    for (int c = 6; c <= 10; c++) any_v = any_v | cv[c];
    checks++;
    if (any_v !== 1'b0 || cb[7] !== 1'b0) begin
      failures++; $display("FAIL rstmid_quiet: got valid %b busy %b exp 0 0", any_v, cb[7]);
    end
    checks++;
    if (ce[8] !== 1'b1 || cv[11] !== 1'b1 || cr[11] !== 64'd2 || cb[12] !== 1'b0) begin
      failures++; $display("FAIL rstmid_restart: got rd%b v%b %h b%b exp rd1 v1 2 b0", ce[8], cv[11], cr[11], cb[12]);
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < 128; e++) vmem[r][e] = '0;
    vmem[2][0] = 64'd1; vmem[2][1] = 64'd2; vmem[2][2] = 64'd3; vmem[2][3] = 64'h8000_0000_0000_0000;
    vmem[5][0] = 64'h1; vmem[5][1] = 64'h2; vmem[5][2] = 64'h3;
    vmem[0][0] = 64'h1; vmem[0][1] = 64'hF000_0000_0000_0000;
    vmem[1][0] = 64'h8000_0000_0000_0001;
    vmem[3][0] = 64'h4;
    for (int e = 0; e < 10; e++) vmem[4][e] = 64'(e + 1);

    test_reset();
    test_streams();
    test_single_elem();
    test_busy_err();
    test_illegal_and_vl0();
    test_back_to_back();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
